// File: rtl/d_cache_nway.sv
// d_cache_nway
//   N-way set-associative, write-back, write-allocate data cache sitting between
//   the MIPS core data port and the AXI-bridge SRAM-like port. Lines hold
//   LINE_WORDS words and are moved as sequential single-word beats. Replacement
//   is tree-PLRU; addresses in kseg1 (addr[31:29] == 3'b101) bypass the cache.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cpu_data_*               core side: req/wr/size/addr/wdata in,
//                            rdata/addr_ok/data_ok out (addr_ok == data_ok)
//   cache_data_*             memory side: req/wr/size/addr/wdata out,
//                            rdata/addr_ok/data_ok in
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | evaluate core request: hit served same cycle, miss/uncached leave
// WB     | write dirty victim line back, beat 0 .. LINE_WORDS-1
// RF     | refill victim way from memory, then replay request as a hit
// UNC    | single pass-through access for an uncached address

module d_cache_nway #(
   parameter int INDEX_WIDTH  = 7,
   parameter int OFFSET_WIDTH = 4,
   parameter int WAYS         = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_data_req,
   input  logic        cpu_data_wr,
   input  logic [1:0]  cpu_data_size,
   input  logic [31:0] cpu_data_addr,
   input  logic [31:0] cpu_data_wdata,
   output logic [31:0] cpu_data_rdata,
   output logic        cpu_data_addr_ok,
   output logic        cpu_data_data_ok,
   output logic        cache_data_req,
   output logic        cache_data_wr,
   output logic [1:0]  cache_data_size,
   output logic [31:0] cache_data_addr,
   output logic [31:0] cache_data_wdata,
   input  logic [31:0] cache_data_rdata,
   input  logic        cache_data_addr_ok,
   input  logic        cache_data_data_ok
);

   localparam int SETS       = 1 << INDEX_WIDTH;
   localparam int LINE_WORDS = 1 << (OFFSET_WIDTH - 2);
   localparam int TAG_WIDTH  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
   localparam int BEAT_W     = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;
   localparam int WAY_W      = (WAYS > 2) ? 2 : 1;
   localparam int PLRU_W     = WAYS - 1;
   localparam int DIDX_W     = INDEX_WIDTH + BEAT_W;
   localparam int DEPTH      = SETS * LINE_WORDS;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WB   = 2'd1;
   localparam logic [1:0] S_RF   = 2'd2;
   localparam logic [1:0] S_UNC  = 2'd3;

   logic [1:0]             r_state;
   logic [BEAT_W-1:0]      r_beat;
   logic                   r_addr_done;
   logic [TAG_WIDTH-1:0]   r_tag_l;
   logic [TAG_WIDTH-1:0]   r_vtag;
   logic [INDEX_WIDTH-1:0] r_idx;
   logic [WAY_W-1:0]       r_victim;

   logic [SETS-1:0]        r_valid [WAYS];
   logic [SETS-1:0]        r_dirty [WAYS];
   logic [PLRU_W-1:0]      r_plru  [SETS];
   logic [TAG_WIDTH-1:0]   r_tag   [WAYS][SETS];
   logic [31:0]            r_data  [WAYS][DEPTH];

   logic [TAG_WIDTH-1:0]   w_tag;
   logic [INDEX_WIDTH-1:0] w_idx;
   logic [BEAT_W-1:0]      w_word;
   logic [DIDX_W-1:0]      w_didx;
   logic [DIDX_W-1:0]      w_fidx;
   logic                   w_uncached;
   logic                   w_hit;
   logic [WAY_W-1:0]       w_hit_way;
   logic                   w_inv_found;
   logic [WAY_W-1:0]       w_inv_way;
   logic [WAY_W-1:0]       w_victim;
   logic                   w_vic_dirty;
   logic [PLRU_W-1:0]      w_plru_cur;
   logic [PLRU_W-1:0]      w_plru_next;
   logic [WAY_W-1:0]       w_plru_way;
   logic [31:0]            w_hit_word;
   logic [3:0]             w_be;
   logic [31:0]            w_merged;
   logic                   w_hit_ok;
   logic                   w_mem_req;
   logic                   w_beat_done;
   logic                   w_last;
   logic [31:0]            w_wb_addr;
   logic [31:0]            w_rf_addr;

   assign w_tag      = cpu_data_addr[31:INDEX_WIDTH+OFFSET_WIDTH];
   assign w_idx      = cpu_data_addr[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
   assign w_uncached = (cpu_data_addr[31:29] == 3'b101);

   generate
      if (OFFSET_WIDTH > 2) begin : g_word
         assign w_word = cpu_data_addr[OFFSET_WIDTH-1:2];
      end else begin : g_word1
         assign w_word = '0;
      end
   endgenerate

   // Flat word index into a way's data array: {set, word within line}
   assign w_didx = (DIDX_W'(w_idx) << (OFFSET_WIDTH - 2)) | DIDX_W'(w_word);
   assign w_fidx = (DIDX_W'(r_idx) << (OFFSET_WIDTH - 2)) | DIDX_W'(r_beat);

   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
      end
   end

   // Scan downward so the lowest-index invalid way wins
   always_comb begin
      w_inv_found = 1'b0;
      w_inv_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!r_valid[w][w_idx]) begin
            w_inv_found = 1'b1;
            w_inv_way   = WAY_W'(w);
         end
      end
   end

   assign w_plru_cur = r_plru[w_idx];

   // PLRU bits point away from the most recently used way.
   // 4-way tree: bit0 = root (0 -> ways 0/1), bit1 = leaf of ways 0/1,
   // bit2 = leaf of ways 2/3.
   generate
      if (WAYS == 4) begin : g_plru4
         assign w_plru_way  = w_plru_cur[0] ? {1'b1, w_plru_cur[2]}
                                            : {1'b0, w_plru_cur[1]};
         assign w_plru_next = w_hit_way[1] ? {~w_hit_way[0], w_plru_cur[1], 1'b0}
                                           : {w_plru_cur[2], ~w_hit_way[0], 1'b1};
      end else begin : g_plru2
         assign w_plru_way  = w_plru_cur;
         assign w_plru_next = ~w_hit_way;
      end
   endgenerate

   assign w_victim    = w_inv_found ? w_inv_way : w_plru_way;
   assign w_vic_dirty = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];

   assign w_hit_word = r_data[w_hit_way][w_didx];

   always_comb begin
      case (cpu_data_size)
         2'd0:    w_be = 4'b0001 << cpu_data_addr[1:0];
         2'd1:    w_be = cpu_data_addr[1] ? 4'b1100 : 4'b0011;
         default: w_be = 4'b1111;
      endcase
   end

   always_comb begin
      w_merged = w_hit_word;
      for (int b = 0; b < 4; b++) begin
         if (w_be[b]) w_merged[8*b +: 8] = cpu_data_wdata[8*b +: 8];
      end
   end

   assign w_hit_ok = !rst && (r_state == S_IDLE) && cpu_data_req && !w_uncached && w_hit;

   // One outstanding beat: req stays up until addr_ok, then drops until data_ok
   assign w_mem_req   = !rst && (r_state != S_IDLE) && !r_addr_done;
   assign w_beat_done = !rst && (r_state != S_IDLE) && cache_data_data_ok &&
                        (r_addr_done || cache_data_addr_ok);
   assign w_last      = (r_beat == BEAT_W'(LINE_WORDS - 1));

   assign w_wb_addr = {r_vtag,  r_idx, OFFSET_WIDTH'(0)} | (32'(r_beat) << 2);
   assign w_rf_addr = {r_tag_l, r_idx, OFFSET_WIDTH'(0)} | (32'(r_beat) << 2);

   assign cpu_data_data_ok = w_hit_ok || ((r_state == S_UNC) && w_beat_done);
   assign cpu_data_addr_ok = cpu_data_data_ok;
   assign cpu_data_rdata   = (r_state == S_UNC) ? cache_data_rdata : w_hit_word;

   assign cache_data_req   = w_mem_req;
   assign cache_data_wr    = !rst && ((r_state == S_WB) || ((r_state == S_UNC) && cpu_data_wr));
   assign cache_data_size  = (r_state == S_UNC) ? cpu_data_size : 2'd2;
   assign cache_data_wdata = (r_state == S_WB) ? r_data[r_victim][w_fidx] : cpu_data_wdata;

   always_comb begin
      case (r_state)
         S_WB:    cache_data_addr = w_wb_addr;
         S_RF:    cache_data_addr = w_rf_addr;
         S_UNC:   cache_data_addr = cpu_data_addr;
         default: cache_data_addr = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_beat      <= '0;
         r_addr_done <= 1'b0;
         r_tag_l     <= '0;
         r_vtag      <= '0;
         r_idx       <= '0;
         r_victim    <= '0;
         for (int w = 0; w < WAYS; w++) begin
            r_valid[w] <= '0;
            r_dirty[w] <= '0;
         end
         for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
      end else begin
         if (r_state != S_IDLE) begin
            if (w_beat_done)                          r_addr_done <= 1'b0;
            else if (w_mem_req && cache_data_addr_ok) r_addr_done <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (cpu_data_req) begin
                  if (w_uncached) begin
                     r_state <= S_UNC;
                  end else if (w_hit) begin
                     r_plru[w_idx] <= w_plru_next;
                     if (cpu_data_wr) r_dirty[w_hit_way][w_idx] <= 1'b1;
                  end else begin
                     r_tag_l  <= w_tag;
                     r_idx    <= w_idx;
                     r_victim <= w_victim;
                     r_vtag   <= r_tag[w_victim][w_idx];
                     r_state  <= w_vic_dirty ? S_WB : S_RF;
                  end
               end
            end
            S_WB: begin
               if (w_beat_done) begin
                  r_beat <= w_last ? '0 : r_beat + 1'b1;
                  if (w_last) r_state <= S_RF;
               end
            end
            S_RF: begin
               if (w_beat_done) begin
                  r_beat <= w_last ? '0 : r_beat + 1'b1;
                  if (w_last) begin
                     r_valid[r_victim][r_idx] <= 1'b1;
                     r_dirty[r_victim][r_idx] <= 1'b0;
                     r_state                  <= S_IDLE;
                  end
               end
            end
            default: begin
               if (w_beat_done) r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Tag and data arrays carry no reset; valid bits qualify them
   always_ff @(posedge clk) begin
      if (w_hit_ok && cpu_data_wr) r_data[w_hit_way][w_didx] <= w_merged;
      if ((r_state == S_RF) && w_beat_done) begin
         r_data[r_victim][w_fidx] <= cache_data_rdata;
         if (w_last) r_tag[r_victim][r_idx] <= r_tag_l;
      end
   end

endmodule

// File: tb/tb_d_cache_nway.sv
module tb_d_cache_nway;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_data_req;
   logic        cpu_data_wr;
   logic [1:0]  cpu_data_size;
   logic [31:0] cpu_data_addr;
   logic [31:0] cpu_data_wdata;
   logic [31:0] cpu_data_rdata;
   logic        cpu_data_addr_ok;
   logic        cpu_data_data_ok;
   logic        cache_data_req;
   logic        cache_data_wr;
   logic [1:0]  cache_data_size;
   logic [31:0] cache_data_addr;
   logic [31:0] cache_data_wdata;
   logic [31:0] cache_data_rdata;
   logic        cache_data_addr_ok;
   logic        cache_data_data_ok;

   always #5 clk = ~clk;

   d_cache_nway dut (
      .clk                (clk),
      .rst                (rst),
      .cpu_data_req       (cpu_data_req),
      .cpu_data_wr        (cpu_data_wr),
      .cpu_data_size      (cpu_data_size),
      .cpu_data_addr      (cpu_data_addr),
      .cpu_data_wdata     (cpu_data_wdata),
      .cpu_data_rdata     (cpu_data_rdata),
      .cpu_data_addr_ok   (cpu_data_addr_ok),
      .cpu_data_data_ok   (cpu_data_data_ok),
      .cache_data_req     (cache_data_req),
      .cache_data_wr      (cache_data_wr),
      .cache_data_size    (cache_data_size),
      .cache_data_addr    (cache_data_addr),
      .cache_data_wdata   (cache_data_wdata),
      .cache_data_rdata   (cache_data_rdata),
      .cache_data_addr_ok (cache_data_addr_ok),
      .cache_data_data_ok (cache_data_data_ok)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Memory model: read data = address; addr_ok after mem_delay waiting cycles;
   // data_ok with addr_ok, or one cycle later when mem_split is set.
   int          mem_delay = 0;
   bit          mem_split = 1'b0;
   logic [31:0] lg_addr [$];
   logic [31:0] lg_wdata [$];
   logic        lg_wr [$];
   logic [1:0]  lg_size [$];
   int          lg_rc [$];
   int          rc = 0;
   bit          pend = 1'b0;
   logic [31:0] pend_addr;
   logic [31:0] first_addr;
   int          proto_err = 0;

   initial begin
      cache_data_addr_ok = 1'b0;
      cache_data_data_ok = 1'b0;
      cache_data_rdata   = '0;
      forever begin
         @(negedge clk);
         #1;
         cache_data_addr_ok = 1'b0;
         cache_data_data_ok = 1'b0;
         if (rst) begin
            pend = 1'b0;
            rc   = 0;
         end else if (pend) begin
            if (cache_data_req) proto_err++;
            cache_data_data_ok = 1'b1;
            cache_data_rdata   = pend_addr;
            pend               = 1'b0;
         end else if (cache_data_req) begin
            if (rc == 0) first_addr = cache_data_addr;
            else if (cache_data_addr !== first_addr) proto_err++;
            if (rc == mem_delay) begin
               cache_data_addr_ok = 1'b1;
               lg_addr.push_back(cache_data_addr);
               lg_wdata.push_back(cache_data_wdata);
               lg_wr.push_back(cache_data_wr);
               lg_size.push_back(cache_data_size);
               lg_rc.push_back(rc + 1);
               if (mem_split) begin
                  pend      = 1'b1;
                  pend_addr = cache_data_addr;
               end else begin
                  cache_data_data_ok = 1'b1;
                  cache_data_rdata   = cache_data_addr;
               end
               rc = 0;
            end else begin
               rc++;
            end
         end
      end
   end

   task automatic clear_log();
      lg_addr.delete();
      lg_wdata.delete();
      lg_wr.delete();
      lg_size.delete();
      lg_rc.delete();
   endtask

   task automatic cpu_access(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
      bit done;
      done  = 1'b0;
      lat   = 0;
      rdata = '0;
      @(negedge clk);
      cpu_data_req   = 1'b1;
      cpu_data_wr    = wr;
      cpu_data_size  = size;
      cpu_data_addr  = addr;
      cpu_data_wdata = wdata;
      while (!done && lat < 200) begin
         #2;
         if (cpu_data_data_ok) begin
            rdata = cpu_data_rdata;
            done  = 1'b1;
         end else begin
            @(negedge clk);
            lat++;
         end
      end
      check_val("access_done", 32'(done), 32'd1);
      if (done) begin
         @(posedge clk);
         #1;
      end
      cpu_data_req = 1'b0;
   endtask

   task automatic do_load(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                          input int exp_lat, input int exp_n);
      logic [31:0] rd;
      int          lat;
      clear_log();
      cpu_access(1'b0, 2'd2, addr, 32'd0, rd, lat);
      check_val({tag, "_rdata"}, rd, exp);
      check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check_val({tag, "_nmem"}, 32'(lg_addr.size()), 32'(exp_n));
   endtask

   task automatic do_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
      logic [31:0] rd;
      int          lat;
      clear_log();
      cpu_access(1'b1, size, addr, wdata, rd, lat);
      check_val({tag, "_lat"}, 32'(lat), 32'd0);
      check_val({tag, "_nmem"}, 32'(lg_addr.size()), 32'd0);
   endtask

   // Four consecutive logged beats starting at log entry 'start'
   task automatic check_beats(input string tag, input int start, input logic [31:0] base,
                              input logic wr);
      for (int i = 0; i < 4; i++) begin
         check_val({tag, "_addr"}, lg_addr[start+i], base + 32'(4 * i));
         check_val({tag, "_wr"}, 32'(lg_wr[start+i]), 32'(wr));
         check_val({tag, "_size"}, 32'(lg_size[start+i]), 32'd2);
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] exp_wb [4];
      int          lat;
      int          k;

      rst            = 1'b1;
      cpu_data_req   = 1'b0;
      cpu_data_wr    = 1'b0;
      cpu_data_size  = 2'd0;
      cpu_data_addr  = '0;
      cpu_data_wdata = '0;

      repeat (3) @(negedge clk);
      #2;
      check_val("rst_data_ok", 32'(cpu_data_data_ok), 32'd0);
      check_val("rst_addr_ok", 32'(cpu_data_addr_ok), 32'd0);
      check_val("rst_req", 32'(cache_data_req), 32'd0);
      check_val("rst_wr", 32'(cache_data_wr), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // cold miss, replay hit, second word hit
      do_load("cold40", 32'h0000_0040, 32'h0000_0040, 5, 4);
      check_beats("cold40", 0, 32'h0000_0040, 1'b0);
      do_load("hit48", 32'h0000_0048, 32'h0000_0048, 0, 0);

      // byte store merges into the line, no memory traffic
      do_store("st41", 2'd0, 32'h0000_0041, 32'h0000_AB00);
      do_load("rd40", 32'h0000_0040, 32'h0000_AB40, 0, 0);

      // halfword / word / high-byte masks on a separate line
      do_load("cold100", 32'h0000_0100, 32'h0000_0100, 5, 4);
      do_store("sth10a", 2'd1, 32'h0000_010A, 32'h1234_0000);
      do_store("stw104", 2'd2, 32'h0000_0104, 32'hDEAD_BEEF);
      do_store("stb10f", 2'd0, 32'h0000_010F, 32'h7700_0000);
      do_load("rd108", 32'h0000_0108, 32'h1234_0108, 0, 0);
      do_load("rd104", 32'h0000_0104, 32'hDEAD_BEEF, 0, 0);
      do_load("rd10c", 32'h0000_010C, 32'h7700_010C, 0, 0);
      do_load("rd100", 32'h0000_0100, 32'h0000_0100, 0, 0);

      // same set, PLRU victim selection and write-back of the dirty line
      do_load("fill840", 32'h0000_0840, 32'h0000_0840, 5, 4);
      check_beats("fill840", 0, 32'h0000_0840, 1'b0);
      do_load("mru40", 32'h0000_0040, 32'h0000_AB40, 0, 0);
      do_load("fill1040", 32'h0000_1040, 32'h0000_1040, 5, 4);
      check_beats("fill1040", 0, 32'h0000_1040, 1'b0);
      do_load("wb840", 32'h0000_0840, 32'h0000_0840, 9, 8);
      check_beats("wb40", 0, 32'h0000_0040, 1'b1);
      check_beats("rf840", 4, 32'h0000_0840, 1'b0);
      exp_wb = '{32'h0000_AB40, 32'h0000_0044, 32'h0000_0048, 32'h0000_004C};
      for (int i = 0; i < 4; i++) check_val("wb40_wdata", lg_wdata[i], exp_wb[i]);

      // uncached bypass, twice; cached contents unaffected
      for (int r = 0; r < 2; r++) begin
         do_load("unc", 32'hA000_0010, 32'hA000_0010, 1, 1);
         check_val("unc_addr", lg_addr[0], 32'hA000_0010);
         check_val("unc_size", 32'(lg_size[0]), 32'd2);
         check_val("unc_wr", 32'(lg_wr[0]), 32'd0);
      end
      do_load("post_unc840", 32'h0000_0840, 32'h0000_0840, 0, 0);
      do_load("post_unc1040", 32'h0000_1040, 32'h0000_1040, 0, 0);

      // slow bridge: addr_ok after 3 wait cycles, data_ok one cycle later
      mem_delay = 3;
      mem_split = 1'b1;
      proto_err = 0;
      do_load("slow2080", 32'h0000_2080, 32'h0000_2080, 21, 4);
      check_beats("slow2080", 0, 32'h0000_2080, 1'b0);
      for (int i = 0; i < 4; i++) check_val("slow_req_cycles", 32'(lg_rc[i]), 32'd4);
      check_val("slow_proto", 32'(proto_err), 32'd0);
      mem_delay = 0;
      mem_split = 1'b0;

      // reset in the middle of a refill
      clear_log();
      @(negedge clk);
      cpu_data_req   = 1'b1;
      cpu_data_wr    = 1'b0;
      cpu_data_size  = 2'd2;
      cpu_data_addr  = 32'h0000_00C0;
      cpu_data_wdata = '0;
      k = 0;
      while (lg_addr.size() < 2 && k < 50) begin
         @(negedge clk);
         #2;
         k++;
      end
      check_val("mid_rf_reached", 32'(lg_addr.size()), 32'd2);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #2;
      check_val("mid_rst_req", 32'(cache_data_req), 32'd0);
      check_val("mid_rst_data_ok", 32'(cpu_data_data_ok), 32'd0);
      check_val("mid_rst_wr", 32'(cache_data_wr), 32'd0);
      @(negedge clk);
      rst          = 1'b0;
      cpu_data_req = 1'b0;
      #2;
      check_val("post_rst_req", 32'(cache_data_req), 32'd0);
      check_val("post_rst_nmem", 32'(lg_addr.size()), 32'd2);
      do_load("refillC0", 32'h0000_00C0, 32'h0000_00C0, 5, 4);
      check_beats("refillC0", 0, 32'h0000_00C0, 1'b0);
      // previously dirty line must now be invalid and clean: plain refill only
      do_load("post_rst100", 32'h0000_0100, 32'h0000_0100, 5, 4);
      check_beats("post_rst100", 0, 32'h0000_0100, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
